// File: rtl/datamover_cmd_responder_if.sv
// Command, MM2S payload and status streams between a DataMover command issuer
// (master) and the responder that serves it (slave).
interface datamover_cmd_responder_if;
  logic        S_AXIS_CMD_TVALID;
  logic        S_AXIS_CMD_TREADY;
  logic [71:0] S_AXIS_CMD_TDATA;

  logic        M_AXIS_MM2S_TVALID;
  logic        M_AXIS_MM2S_TREADY;
  logic [31:0] M_AXIS_MM2S_TDATA;
  logic [3:0]  M_AXIS_MM2S_TKEEP;
  logic        M_AXIS_MM2S_TLAST;

  logic        M_AXIS_STS_TVALID;
  logic        M_AXIS_STS_TREADY;
  logic [7:0]  M_AXIS_STS_TDATA;

  modport master (
    output S_AXIS_CMD_TVALID, S_AXIS_CMD_TDATA,
    output M_AXIS_MM2S_TREADY, M_AXIS_STS_TREADY,
    input  S_AXIS_CMD_TREADY,
    input  M_AXIS_MM2S_TVALID, M_AXIS_MM2S_TDATA, M_AXIS_MM2S_TKEEP, M_AXIS_MM2S_TLAST,
    input  M_AXIS_STS_TVALID, M_AXIS_STS_TDATA
  );

  modport slave (
    input  S_AXIS_CMD_TVALID, S_AXIS_CMD_TDATA,
    input  M_AXIS_MM2S_TREADY, M_AXIS_STS_TREADY,
    output S_AXIS_CMD_TREADY,
    output M_AXIS_MM2S_TVALID, M_AXIS_MM2S_TDATA, M_AXIS_MM2S_TKEEP, M_AXIS_MM2S_TLAST,
    output M_AXIS_STS_TVALID, M_AXIS_STS_TDATA
  );
endinterface

// File: rtl/datamover_cmd_responder.sv
// DataMover MM2S stand-in: accepts one command at a time, streams an address
// pattern (SADDR + 4*i) as payload, then returns the 8-bit status word.
module datamover_cmd_responder #(
  parameter int unsigned C_S_AXIS_CMD_DATA_WIDTH = 72,
  parameter int unsigned C_M_AXIS_STS_DATA_WIDTH = 8,
  parameter int unsigned C_M_AXIS_DATA_WIDTH     = 32,
  parameter logic [31:0] C_ADDR_LIMIT            = 32'h4000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  datamover_cmd_responder_if.slave   bus,
  output logic                       busy
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STS
  } state_t;

  state_t                             state_q, state_d;
  logic                               cmd_tready_q, cmd_tready_d;
  logic                               mm2s_tvalid_q, mm2s_tvalid_d;
  logic [C_M_AXIS_DATA_WIDTH-1:0]     mm2s_tdata_q, mm2s_tdata_d;
  logic [3:0]                         mm2s_tkeep_q, mm2s_tkeep_d;
  logic                               mm2s_tlast_q, mm2s_tlast_d;
  logic                               sts_tvalid_q, sts_tvalid_d;
  logic [C_M_AXIS_STS_DATA_WIDTH-1:0] sts_tdata_q, sts_tdata_d;
  logic [20:0]                        beats_q, beats_d;
  logic [1:0]                         btt_lo_q, btt_lo_d;
  logic                               eof_q, eof_d;
  logic [3:0]                         tag_q, tag_d;

  logic [C_S_AXIS_CMD_DATA_WIDTH-1:0] cmd;
  logic [22:0]                        cmd_btt;
  logic                               cmd_eof;
  logic [31:0]                        cmd_saddr;
  logic [3:0]                         cmd_tag;
  logic [22:0]                        btt_m1;
  logic [20:0]                        beats_load;
  logic                               unused_cmd_bits;

  assign cmd        = bus.S_AXIS_CMD_TDATA;
  assign cmd_btt    = cmd[22:0];
  assign cmd_eof    = cmd[30];
  assign cmd_saddr  = cmd[63:32];
  assign cmd_tag    = cmd[67:64];
  // Counter holds beats remaining after the current one, so 2^21 beats fit in 21 bits.
  assign btt_m1     = cmd_btt - 23'd1;
  assign beats_load = btt_m1[22:2];

  assign unused_cmd_bits = ^{cmd[71:68], cmd[31], cmd[29:23], btt_m1[1:0]};

  function automatic logic [3:0] last_keep(input logic [1:0] rem);
    case (rem)
      2'd1:    return 4'h1;
      2'd2:    return 4'h3;
      2'd3:    return 4'h7;
      default: return 4'hF;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    cmd_tready_d = cmd_tready_q;
    mm2s_tvalid_d = mm2s_tvalid_q;
    mm2s_tdata_d = mm2s_tdata_q;
    mm2s_tkeep_d = mm2s_tkeep_q;
    mm2s_tlast_d = mm2s_tlast_q;
    sts_tvalid_d = sts_tvalid_q;
    sts_tdata_d  = sts_tdata_q;
    beats_d      = beats_q;
    btt_lo_d     = btt_lo_q;
    eof_d        = eof_q;
    tag_d        = tag_q;

    case (state_q)
      IDLE: begin
        cmd_tready_d = 1'b1;
        if (cmd_tready_q && bus.S_AXIS_CMD_TVALID) begin
          cmd_tready_d = 1'b0;
          tag_d        = cmd_tag;
          eof_d        = cmd_eof;
          btt_lo_d     = cmd_btt[1:0];
          if (cmd_btt == '0) begin
            state_d      = STS;
            sts_tvalid_d = 1'b1;
            sts_tdata_d  = {1'b0, 1'b0, 1'b0, 1'b1, cmd_tag};
          end else if (cmd_saddr >= C_ADDR_LIMIT) begin
            state_d      = STS;
            sts_tvalid_d = 1'b1;
            sts_tdata_d  = {1'b0, 1'b0, 1'b1, 1'b0, cmd_tag};
          end else begin
            state_d       = DATA;
            mm2s_tvalid_d = 1'b1;
            mm2s_tdata_d  = cmd_saddr;
            beats_d       = beats_load;
            mm2s_tkeep_d  = (beats_load == '0) ? last_keep(cmd_btt[1:0]) : 4'hF;
            mm2s_tlast_d  = (beats_load == '0) && cmd_eof;
          end
        end
      end

      DATA: begin
        if (bus.M_AXIS_MM2S_TREADY) begin
          if (beats_q == '0) begin
            state_d       = STS;
            mm2s_tvalid_d = 1'b0;
            mm2s_tdata_d  = '0;
            mm2s_tkeep_d  = '0;
            mm2s_tlast_d  = 1'b0;
            sts_tvalid_d  = 1'b1;
            sts_tdata_d   = {1'b1, 1'b0, 1'b0, 1'b0, tag_q};
          end else begin
            beats_d      = beats_q - 21'd1;
            mm2s_tdata_d = mm2s_tdata_q + C_M_AXIS_DATA_WIDTH'(4);
            mm2s_tkeep_d = (beats_q == 21'd1) ? last_keep(btt_lo_q) : 4'hF;
            mm2s_tlast_d = (beats_q == 21'd1) && eof_q;
          end
        end
      end

      STS: begin
        if (bus.M_AXIS_STS_TREADY) begin
          state_d      = IDLE;
          sts_tvalid_d = 1'b0;
          sts_tdata_d  = '0;
          cmd_tready_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Async reset drops every VALID immediately and discards any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cmd_tready_q  <= 1'b0;
      mm2s_tvalid_q <= 1'b0;
      mm2s_tdata_q  <= '0;
      mm2s_tkeep_q  <= '0;
      mm2s_tlast_q  <= 1'b0;
      sts_tvalid_q  <= 1'b0;
      sts_tdata_q   <= '0;
      beats_q       <= '0;
      btt_lo_q      <= '0;
      eof_q         <= 1'b0;
      tag_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_tready_q  <= cmd_tready_d;
      mm2s_tvalid_q <= mm2s_tvalid_d;
      mm2s_tdata_q  <= mm2s_tdata_d;
      mm2s_tkeep_q  <= mm2s_tkeep_d;
      mm2s_tlast_q  <= mm2s_tlast_d;
      sts_tvalid_q  <= sts_tvalid_d;
      sts_tdata_q   <= sts_tdata_d;
      beats_q       <= beats_d;
      btt_lo_q      <= btt_lo_d;
      eof_q         <= eof_d;
      tag_q         <= tag_d;
    end
  end

  assign bus.S_AXIS_CMD_TREADY  = cmd_tready_q;
  assign bus.M_AXIS_MM2S_TVALID = mm2s_tvalid_q;
  assign bus.M_AXIS_MM2S_TDATA  = mm2s_tdata_q;
  assign bus.M_AXIS_MM2S_TKEEP  = mm2s_tkeep_q;
  assign bus.M_AXIS_MM2S_TLAST  = mm2s_tlast_q;
  assign bus.M_AXIS_STS_TVALID  = sts_tvalid_q;
  assign bus.M_AXIS_STS_TDATA   = sts_tdata_q;
  assign busy                   = (state_q != IDLE);

endmodule

// File: tb/tb_datamover_cmd_responder.sv
// Drives command vectors into two responders (default and raised address limit)
// and checks payload beats, status words, handshake timing and reset behaviour.
module tb_datamover_cmd_responder;

  typedef struct {
    bit          wrap;
    logic [22:0] btt;
    logic [31:0] saddr;
    logic [3:0]  tag;
    bit          eof;
    bit          rnd;
    logic [7:0]  exp_sts;
    int          exp_beats;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, busy_w;

  always #5 clk = ~clk;

  datamover_cmd_responder_if bus();
  datamover_cmd_responder_if bus_w();

  datamover_cmd_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  datamover_cmd_responder #(.C_ADDR_LIMIT(32'hFFFF_FFFF)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w),
    .busy  (busy_w)
  );

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    beats_seen = 0;
  bit    sel = 1'b0;
  bit    mon_en = 1'b0;
  bit    rnd_rdy = 1'b0;
  bit    hold_sts = 1'b0;
  beat_t exp_beats[$];
  logic [7:0] exp_sts[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Sink ready generation: always ready, random stalls, or status held off.
  initial begin
    logic mr, sr;
    bus.M_AXIS_MM2S_TREADY = 1'b1;
    bus.M_AXIS_STS_TREADY = 1'b1;
    bus_w.M_AXIS_MM2S_TREADY = 1'b1;
    bus_w.M_AXIS_STS_TREADY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      mr = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      sr = hold_sts ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      bus.M_AXIS_MM2S_TREADY = mr;
      bus.M_AXIS_STS_TREADY = sr;
      bus_w.M_AXIS_MM2S_TREADY = mr;
      bus_w.M_AXIS_STS_TREADY = sr;
    end
  end

  // Monitor: scoreboard pops, stall stability, ready rules on the selected DUT.
  logic        m_v, m_r, m_l, s_v, s_r, c_r, m_bz, o_v;
  logic [31:0] m_d;
  logic [3:0]  m_k;
  logic [7:0]  s_d;
  logic        p_mstall = 1'b0, p_sstall = 1'b0, p_shs = 1'b0;
  logic [37:0] p_m;
  logic [8:0]  p_s;
  beat_t       got_b;
  logic [7:0]  got_s;

  always @(negedge clk) begin
    m_v  = sel ? bus_w.M_AXIS_MM2S_TVALID : bus.M_AXIS_MM2S_TVALID;
    m_r  = sel ? bus_w.M_AXIS_MM2S_TREADY : bus.M_AXIS_MM2S_TREADY;
    m_d  = sel ? bus_w.M_AXIS_MM2S_TDATA  : bus.M_AXIS_MM2S_TDATA;
    m_k  = sel ? bus_w.M_AXIS_MM2S_TKEEP  : bus.M_AXIS_MM2S_TKEEP;
    m_l  = sel ? bus_w.M_AXIS_MM2S_TLAST  : bus.M_AXIS_MM2S_TLAST;
    s_v  = sel ? bus_w.M_AXIS_STS_TVALID  : bus.M_AXIS_STS_TVALID;
    s_r  = sel ? bus_w.M_AXIS_STS_TREADY  : bus.M_AXIS_STS_TREADY;
    s_d  = sel ? bus_w.M_AXIS_STS_TDATA   : bus.M_AXIS_STS_TDATA;
    c_r  = sel ? bus_w.S_AXIS_CMD_TREADY  : bus.S_AXIS_CMD_TREADY;
    m_bz = sel ? busy_w : busy;
    o_v  = sel ? (bus.M_AXIS_MM2S_TVALID | bus.M_AXIS_STS_TVALID)
               : (bus_w.M_AXIS_MM2S_TVALID | bus_w.M_AXIS_STS_TVALID);
    if (!mon_en) begin
      p_mstall = 1'b0;
      p_sstall = 1'b0;
      p_shs = 1'b0;
    end else begin
      if (p_mstall) checkOutput("mm2s_hold", {m_v, m_d, m_k, m_l}, p_m);
      if (p_sstall) checkOutput("sts_hold", {s_v, s_d}, p_s);
      if (p_shs) checkOutput("cmd_ready_after_sts", c_r, 1);
      if (m_bz) checkOutput("cmd_ready_while_busy", c_r, 0);
      checkOutput("other_dut_quiet", o_v, 0);
      if (m_v && m_r) begin
        beats_seen++;
        if (exp_beats.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_beat: got data 0x%0h with no beat expected", m_d);
        end else begin
          got_b = exp_beats.pop_front();
          checkOutput("beat_data", m_d, got_b.data);
          checkOutput("beat_keep", m_k, got_b.keep);
          checkOutput("beat_last", m_l, got_b.last);
        end
      end
      if (s_v && s_r) begin
        if (exp_sts.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_status: got 0x%0h with no status expected", s_d);
        end else begin
          got_s = exp_sts.pop_front();
          checkOutput("status_word", s_d, got_s);
        end
      end
      p_mstall = m_v && !m_r;
      p_m = {m_v, m_d, m_k, m_l};
      p_sstall = s_v && !s_r;
      p_s = {s_v, s_d};
      p_shs = s_v && s_r;
    end
  end

  function automatic logic [71:0] cmdWord(input vec_t v);
    logic [31:0] r;
    r = $urandom;
    return {r[3:0], v.tag, v.saddr, r[4], v.eof, r[10:5], r[11], v.btt};
  endfunction

  task automatic setCmd(input bit w, input logic vld, input logic [71:0] d);
    if (w) begin
      bus_w.S_AXIS_CMD_TVALID = vld;
      bus_w.S_AXIS_CMD_TDATA = d;
    end else begin
      bus.S_AXIS_CMD_TVALID = vld;
      bus.S_AXIS_CMD_TDATA = d;
    end
  endtask

  // Reference model of the payload: address pattern, partial last keep, EOF-gated TLAST.
  task automatic pushExpected(input vec_t v);
    int n;
    beat_t b;
    logic [31:0] limit;
    limit = v.wrap ? 32'hFFFF_FFFF : 32'h4000_0000;
    n = (int'(v.btt) + 3) / 4;
    if (v.saddr >= limit) n = 0;
    for (int i = 0; i < n; i++) begin
      b.data = v.saddr + 32'(4 * i);
      b.keep = 4'hF;
      if (i == n - 1 && v.btt[1:0] != 2'd0) b.keep = 4'((1 << v.btt[1:0]) - 1);
      b.last = (i == n - 1) && v.eof;
      exp_beats.push_back(b);
    end
    exp_sts.push_back(v.exp_sts);
  endtask

  task automatic driveCmd(input bit w, input logic [71:0] word, output int acc);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    acc = -1;
    @(posedge clk);
    #1;
    setCmd(w, 1'b1, word);
    while (!got && n < 200) begin
      @(negedge clk);
      if (w ? bus_w.S_AXIS_CMD_TREADY : bus.S_AXIS_CMD_TREADY) begin
        got = 1'b1;
        acc = cyc + 1;
      end
      n++;
    end
    @(posedge clk);
    #1;
    setCmd(w, 1'b0, word);
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL cmd_accept_timeout: got no ready, required ready within 200 cycles");
    end
  endtask

  task automatic waitStatus(input bit w, output int fb, output int fs, output int hs);
    int n;
    fb = -1;
    fs = -1;
    hs = -1;
    n = 0;
    while (hs < 0 && n < 3000) begin
      @(negedge clk);
      if ((w ? bus_w.M_AXIS_MM2S_TVALID : bus.M_AXIS_MM2S_TVALID) && fb < 0) fb = cyc;
      if ((w ? bus_w.M_AXIS_STS_TVALID : bus.M_AXIS_STS_TVALID) && fs < 0) fs = cyc;
      if ((w ? bus_w.M_AXIS_STS_TVALID : bus.M_AXIS_STS_TVALID) &&
          (w ? bus_w.M_AXIS_STS_TREADY : bus.M_AXIS_STS_TREADY)) hs = cyc + 1;
      n++;
    end
    if (hs < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL status_timeout: got no status handshake, required within 3000 cycles");
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int acc, fb, fs, hs;
    sel = v.wrap;
    rnd_rdy = v.rnd;
    beats_seen = 0;
    pushExpected(v);
    driveCmd(v.wrap, cmdWord(v), acc);
    waitStatus(v.wrap, fb, fs, hs);
    rnd_rdy = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("beat_count", beats_seen, v.exp_beats);
    checkOutput("beats_drained", exp_beats.size(), 0);
    checkOutput("status_drained", exp_sts.size(), 0);
    if (!v.rnd) begin
      checkOutput("sts_latency", fs - acc, v.exp_beats);
      if (v.exp_beats > 0) checkOutput("first_beat_latency", fb - acc, 0);
    end
  endtask

  vec_t vecs[9];
  vec_t va, vb, vr, ve;

  initial begin
    int acc_a, acc_b, fb, fs, hs_a, hs_b;
    vecs[0] = '{0, 23'd16, 32'h0000_1000, 4'd5,  1, 0, 8'h85, 4};
    vecs[1] = '{0, 23'd7,  32'h0000_0020, 4'd3,  0, 0, 8'h83, 2};
    vecs[2] = '{0, 23'd0,  32'h0000_0000, 4'd9,  1, 0, 8'h19, 0};
    vecs[3] = '{0, 23'd8,  32'h4000_0000, 4'd2,  1, 0, 8'h22, 0};
    vecs[4] = '{1, 23'd12, 32'hFFFF_FFFC, 4'd1,  1, 1, 8'h81, 3};
    vecs[5] = '{0, 23'd5,  32'h3FFF_FFFC, 4'd7,  1, 0, 8'h87, 2};
    vecs[6] = '{0, 23'd3,  32'h0000_0100, 4'hA,  1, 1, 8'h8A, 1};
    vecs[7] = '{0, 23'd40, 32'h0000_0200, 4'hF,  0, 1, 8'h8F, 10};
    vecs[8] = '{0, 23'd4,  32'h0000_0000, 4'd0,  1, 0, 8'h80, 1};

    setCmd(0, 1'b0, '0);
    setCmd(1, 1'b0, '0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", {bus.S_AXIS_CMD_TREADY, bus.M_AXIS_MM2S_TVALID, bus.M_AXIS_MM2S_TDATA,
                                  bus.M_AXIS_MM2S_TKEEP, bus.M_AXIS_MM2S_TLAST, bus.M_AXIS_STS_TVALID,
                                  bus.M_AXIS_STS_TDATA, busy}, 0);
    checkOutput("reset_outputs_w", {bus_w.S_AXIS_CMD_TREADY, bus_w.M_AXIS_MM2S_TVALID, bus_w.M_AXIS_MM2S_TDATA,
                                    bus_w.M_AXIS_MM2S_TKEEP, bus_w.M_AXIS_MM2S_TLAST, bus_w.M_AXIS_STS_TVALID,
                                    bus_w.M_AXIS_STS_TDATA, busy_w}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("cmd_ready_after_reset", bus.S_AXIS_CMD_TREADY, 1);
    checkOutput("cmd_ready_after_reset_w", bus_w.S_AXIS_CMD_TREADY, 1);
    mon_en = 1'b1;

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Second command held valid while the first is in flight.
    va = '{0, 23'd8, 32'h0000_0300, 4'd4, 1, 0, 8'h84, 2};
    vb = '{0, 23'd4, 32'h0000_0400, 4'd6, 0, 0, 8'h86, 1};
    sel = 1'b0;
    beats_seen = 0;
    pushExpected(va);
    driveCmd(0, cmdWord(va), acc_a);
    pushExpected(vb);
    setCmd(0, 1'b1, cmdWord(vb));
    waitStatus(0, fb, fs, hs_a);
    driveCmd(0, bus.S_AXIS_CMD_TDATA, acc_b);
    checkOutput("second_cmd_accept_gap", acc_b - hs_a, 1);
    waitStatus(0, fb, fs, hs_b);
    @(posedge clk);
    #1;
    checkOutput("pair_beat_count", beats_seen, 3);
    checkOutput("pair_drained", exp_beats.size() + exp_sts.size(), 0);

    // Reset pulse in the middle of a long payload.
    vr = '{0, 23'd64, 32'h0000_0800, 4'd1, 1, 0, 8'h81, 16};
    pushExpected(vr);
    driveCmd(0, cmdWord(vr), acc_a);
    repeat (3) @(negedge clk);
    checkOutput("mid_data_valid", bus.M_AXIS_MM2S_TVALID, 1);
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_drops_data", {bus.M_AXIS_MM2S_TVALID, bus.M_AXIS_STS_TVALID, bus.S_AXIS_CMD_TREADY, busy}, 0);
    exp_beats.delete();
    exp_sts.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    applyStimulus(vecs[1]);

    // Reset pulse while a status word is stalled.
    ve = '{0, 23'd0, 32'h0, 4'd1, 1, 0, 8'h11, 0};
    hold_sts = 1'b1;
    driveCmd(0, cmdWord(ve), acc_a);
    repeat (3) @(negedge clk);
    checkOutput("sts_pending", {bus.M_AXIS_STS_TVALID, bus.M_AXIS_STS_TDATA}, {1'b1, ve.exp_sts});
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_drops_sts", {bus.M_AXIS_STS_TVALID, bus.M_AXIS_STS_TDATA, busy}, 0);
    hold_sts = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    applyStimulus(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
